uart_autobaud: RTL and testbench
================================

# uart_autobaud

Measures the bit period of an incoming 0x55 sync character on the UART receive line and produces the matching prescaler value for `uart_baud_gen`. It performs the inverse of the baud generator: it turns an observed line rate into a prescaler value rather than a prescaler value into ticks. It sits between the raw `rx` pin and the prescaler input of the baud generators for both the transmitter and the receiver, and is armed by the host or controller before the link is brought up.

## Interface
- `WIDTH`, 21: prescaler width; matches `uart_baud_gen`.
- `DEFAULT_PRESCALER`, 103: prescaler value held after reset (115200 baud at 12 MHz).
- `MIN_PRESCALER`, 3: smallest result accepted; smaller results are an error.
- `CLK`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  raw asynchronous UART line; idle is high.
- `start`  in  1  one-cycle arm request; ignored while `busy`.
- `prescaler`  out  WIDTH  last accepted measurement; reset value `DEFAULT_PRESCALER`.
- `busy`  out  1  armed or measuring; reset value 0.
- `done`  out  1  one-cycle pulse on a successful measurement; reset value 0.
- `err`  out  1  one-cycle pulse on a failed measurement; reset value 0.

## Operation
- **Input conditioning.** `rx` passes through a 2-FF synchronizer whose flops reset to 1. Edges are detected on the synchronized signal. The fixed latency cancels out of all intervals.
- **IDLE.** `busy`=0. On `start`, go to WAIT_HIGH.
- **WAIT_HIGH.** Wait until the synchronized rx is 1, then go to WAIT_START. This prevents a measurement from starting mid-character.
- **WAIT_START.** On a falling edge, clear the interval counter and the total, set the edge index to 0, and go to MEASURE.
- **MEASURE.**
  - The interval counter increments every cycle.
  - On each edge (either polarity), the closed interval length n = counter+1 is added to the total and the counter restarts at 0.
  - Interval 1 (start-bit width) is stored as T0.
  - Intervals 2..8 must satisfy |n − T0| ≤ T0>>2. A violation asserts `err` and returns to IDLE.
  - If the interval counter reaches 2^WIDTH−1 with no edge, assert `err` and return to IDLE.
  - The 8th edge is the falling edge that starts bit 7 and spans 8 bit times. On it, compute the result and go to IDLE.
- **Result.**
  - p = ((total + 4) >> 3) − 1, computed on WIDTH+3 bits and truncated to WIDTH.
  - If p < MIN_PRESCALER, assert `err` and leave `prescaler` unchanged.
  - Otherwise load `prescaler` with p and pulse `done`.
- `done` and `err` are mutually exclusive and never asserted outside the cycle that ends a measurement.
- `prescaler` changes only on a `done` cycle or on reset.
- There is no automatic retry; the controller re-arms with `start`.

## Timing
- `busy` rises in the cycle after `start` is sampled in IDLE. It falls in the same cycle that `done` or `err` is asserted.
- `done`/`err` are registered. They assert 1 cycle after the edge-detect strobe of the terminating edge (or after the timeout/violation detection). `prescaler` is valid in the same cycle as `done`.
- Reset mid-measurement: all state returns to IDLE on the next edge, `prescaler` returns to `DEFAULT_PRESCALER`, and no pulses are issued.
- `start` asserted together with an edge in IDLE: only the arm is acted on; the edge is ignored.
- An edge in the same cycle that the counter hits its maximum counts as an edge, not a timeout.
- Edges after the 8th are ignored; the block is in IDLE by then.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding: IDLE, WAIT_HIGH, WAIT_START, MEASURE;
  - the sync character constant `8'h55`;
  - the edge count constant `8` and tolerance shift `2`, shared with the receiver and transmitter.
- One sub-module, `uart_rx_sync`: 2-FF synchronizer plus registered rise/fall strobes. The UART receiver reuses it.
- The rest (FSM, counter, accumulator, tolerance compare, result register) stays in `uart_autobaud`.

## Test plan
- Reset, no stimulus:
  - `prescaler`=103, `busy`=`done`=`err`=0.
  - Drive `rx`=0 with no `start` → no change.
- Arm, then send 0x55 with a bit period of 104 cycles → exactly one `done` pulse, `prescaler`=103, `busy` low thereafter.
- Arm, then send 0x55 with a bit period of 10 cycles plus ±2-cycle jitter per bit → `done`, `prescaler`=9.
- Arm, then send 0x55 at 100 cycles/bit with bit 3 stretched to 130 → `err` pulse, `prescaler` unchanged at its prior value.
- Arm with `rx` held low → waits in WAIT_HIGH, no pulse. Release high, then hold low forever → `err` after 2^WIDTH−1 cycles (use WIDTH=8: 255 cycles).
- Arm, then send 0x55 at 3 cycles/bit → p=2 < MIN_PRESCALER → `err`. Assert reset mid-measurement on a 104-cycle character → no pulses, `prescaler`=103.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver, transmitter and autobaud blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_START,
        MEASURE
    } ab_state_t;

    localparam logic [7:0]  SYNC_CHAR  = 8'h55;
    localparam int unsigned EDGE_COUNT = 8;
    localparam int unsigned TOL_SHIFT  = 2;
    localparam int unsigned EDGE_IDX_W = $clog2(EDGE_COUNT);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx pin with registered rise/fall strobes.
module uart_rx_sync (
    input  logic CLK,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_d;

    // Flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            rx_s   <= 1'b1;
            sync_d <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= rx;
            rx_s   <= meta;
            sync_d <= rx_s;
            rise   <= rx_s & ~sync_d;
            fall   <= ~rx_s & sync_d;
        end
    end

endmodule

// File: rtl/uart_autobaud.sv
// Measures the bit period of a 0x55 sync character on rx and derives the
// matching uart_baud_gen prescaler value.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH             = 21,
    parameter int unsigned DEFAULT_PRESCALER = 103,
    parameter int unsigned MIN_PRESCALER     = 3
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             start,
    output logic [WIDTH-1:0] prescaler,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [EDGE_IDX_W-1:0] LAST_IDX = EDGE_IDX_W'(EDGE_COUNT - 1);

    logic rx_s, rise, fall, edge_s;

    uart_rx_sync u_sync (
        .CLK   (CLK),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_s = rise | fall;

    ab_state_t             state;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH:0]        t0;
    logic [WIDTH+2:0]      total;
    logic [EDGE_IDX_W-1:0] idx;

    logic [WIDTH:0]        n;
    logic [WIDTH:0]        diff;
    logic [WIDTH+2:0]      sum;
    logic [WIDTH+2:0]      rnd;
    logic [WIDTH-1:0]      p;
    logic                  in_tol;
    logic                  cnt_max;
    logic                  p_ok;

    // n is the length of the interval closed by an edge in this cycle.
    always_comb begin
        n       = (WIDTH+1)'(cnt) + (WIDTH+1)'(1);
        diff    = (n >= t0) ? (n - t0) : (t0 - n);
        in_tol  = diff <= (t0 >> TOL_SHIFT);
        sum     = total + (WIDTH+3)'(n);
        rnd     = sum + (WIDTH+3)'(4);
        p       = WIDTH'((rnd >> EDGE_IDX_W) - (WIDTH+3)'(1));
        p_ok    = p >= WIDTH'(MIN_PRESCALER);
        cnt_max = &cnt;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= WIDTH'(DEFAULT_PRESCALER);
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            t0        <= '0;
            total     <= '0;
            idx       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_HIGH;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= WAIT_START;
                end
                WAIT_START: begin
                    if (fall) begin
                        cnt   <= '0;
                        total <= '0;
                        idx   <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    cnt <= cnt + WIDTH'(1);
                    // An edge on the same cycle as counter saturation wins over timeout.
                    if (edge_s) begin
                        cnt   <= '0;
                        total <= sum;
                        idx   <= idx + EDGE_IDX_W'(1);
                        if (idx == '0) t0 <= n;
                        if (idx != '0 && !in_tol) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                            if (p_ok) begin
                                prescaler <= p;
                                done      <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else if (cnt_max) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed scoreboard bench for uart_autobaud with an 8-bit prescaler.
module tb_uart_autobaud;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         rx;
    logic         start;
    logic [W-1:0] prescaler;
    logic         busy, done, err;

    uart_autobaud #(.WIDTH(W), .DEFAULT_PRESCALER(103), .MIN_PRESCALER(3)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .rx        (rx),
        .start     (start),
        .prescaler (prescaler),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_done;
        logic [7:0]  presc;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   pulse_cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any done/err pulse against the queue.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (done === 1'b1 || err === 1'b1) begin
            pulse_cyc = cyc;
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'({done, err}), 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", 32'({done, err}), e.is_done ? 32'd2 : 32'd1);
                chk("prescaler_at_pulse", 32'(prescaler), 32'(e.presc));
                chk("busy_at_pulse", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    // w[i] = cycles spent on start, b0..b7, stop; 0x55 makes levels alternate from 0.
    task automatic send_char(input int w[0:9], input int abort_at);
        for (int i = 0; i < 10; i++) begin
            rx = i[0];
            if (i == abort_at) begin
                steps(w[i] / 2);
                rst_n = 1'b0;
                steps(2);
                rst_n = 1'b1;
                steps(w[i] - w[i] / 2 - 2);
            end else begin
                steps(w[i]);
            end
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && q.size() != 0; i++) step();
        chk(tag, 32'(q.size()), 32'd0);
        q.delete();
        steps(10);
    endtask

    initial begin
        int w[0:9];
        int c0;

        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        steps(3);
        rst_n = 1'b1;
        step();
        chk("reset_prescaler", 32'(prescaler), 32'd103);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // rx activity without arming must not do anything
        rx = 1'b0;
        steps(20);
        rx = 1'b1;
        steps(10);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_prescaler", 32'(prescaler), 32'd103);

        // 104 cycles/bit -> 103
        arm();
        steps(3);
        w = '{104, 104, 104, 104, 104, 104, 104, 104, 104, 104};
        q.push_back('{1'b1, 8'd103});
        send_char(w, -1);
        drain("done_104");
        chk("busy_after_104", 32'(busy), 32'd0);
        chk("presc_after_104", 32'(prescaler), 32'd103);

        // 10 cycles/bit with +-2 jitter: intervals sum to 80 -> 9
        arm();
        steps(3);
        w = '{10, 12, 8, 12, 8, 12, 8, 10, 10, 10};
        q.push_back('{1'b1, 8'd9});
        send_char(w, -1);
        drain("done_jitter");
        chk("presc_after_jitter", 32'(prescaler), 32'd9);

        // bit 3 stretched to 130 at 100 cycles/bit breaks tolerance
        arm();
        steps(3);
        w = '{100, 100, 100, 100, 130, 100, 100, 100, 100, 100};
        q.push_back('{1'b0, 8'd9});
        send_char(w, -1);
        drain("err_stretch");
        chk("presc_after_stretch", 32'(prescaler), 32'd9);
        chk("busy_after_stretch", 32'(busy), 32'd0);

        // armed with rx low: stays in WAIT_HIGH, then timeout after falling edge
        rx = 1'b0;
        steps(5);
        arm();
        steps(30);
        chk("wait_high_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        steps(5);
        q.push_back('{1'b0, 8'd9});
        rx = 1'b0;
        c0 = cyc;
        drain("err_timeout");
        chk("timeout_latency", 32'(pulse_cyc - c0), 32'd260);
        rx = 1'b1;
        steps(10);
        chk("presc_after_timeout", 32'(prescaler), 32'd9);

        // 3 cycles/bit -> p=2, below the minimum
        arm();
        steps(3);
        w = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        q.push_back('{1'b0, 8'd9});
        send_char(w, -1);
        drain("err_small");
        chk("presc_after_small", 32'(prescaler), 32'd9);

        // reset in the middle of a 104-cycle character: no pulses, default prescaler
        arm();
        steps(3);
        w = '{104, 104, 104, 104, 104, 104, 104, 104, 104, 104};
        send_char(w, 4);
        steps(50);
        chk("presc_after_reset", 32'(prescaler), 32'd103);
        chk("busy_after_reset", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
